// File: rtl/wb_regfile_scoreboard_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | wb_regfile_scoreboard_pkg: shared widths and register-index type        |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package wb_regfile_scoreboard_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_NREG   = 16;
    localparam int WB_ADDR_W = 4;
    localparam int WB_CNT_W  = 2;
    localparam int WB_R0_IDX = 0;

    // Register index as carried by the WriteBack and decode stages.
    typedef logic [WB_ADDR_W-1:0] reg_idx_t;

endpackage
`default_nettype wire

// File: rtl/wb_regfile_scoreboard_sb_counter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | sb_counter: per-register in-flight write counter (up/down, saturating)  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module sb_counter
    import wb_regfile_scoreboard_pkg::*;
#(
    parameter int CNT_W = WB_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             nonzero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Simultaneous inc and dec cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign nonzero = (cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/wb_regfile_scoreboard.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | wb_regfile_scoreboard: write-back register file with RAW scoreboard     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module wb_regfile_scoreboard
    import wb_regfile_scoreboard_pkg::*;
#(
    parameter int DATA_W  = WB_DATA_W,
    parameter int NREG    = WB_NREG,
    parameter int ADDR_W  = WB_ADDR_W,
    parameter int CNT_W   = WB_CNT_W,
    parameter int R0_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_rg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rda_rg,
    input  logic              rda_use,
    output logic [DATA_W-1:0] rda_data,
    input  logic [ADDR_W-1:0] rdb_rg,
    input  logic              rdb_use,
    output logic [DATA_W-1:0] rdb_data,
    input  logic              iss_valid,
    input  logic              iss_we,
    input  logic [ADDR_W-1:0] iss_rg,
    output logic              stall,
    output logic              wb_err,
    output logic              pend_any
);

    localparam logic [ADDR_W-1:0] R0_ADDR = ADDR_W'(WB_R0_IDX);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0]           regs_q [NREG];
    logic [DATA_W-1:0]           regs_d [NREG];
    logic [NREG-1:0][CNT_W-1:0]  cnt;
    logic [NREG-1:0]             cnt_nz;
    logic [NREG-1:0]             inc;
    logic [NREG-1:0]             dec;
    logic                        wb_err_q;
    logic                        wb_err_d;
    logic                        wb_zero_r0;
    logic                        iss_zero_r0;
    logic                        wb_live;
    logic                        haz_a;
    logic                        haz_b;
    logic                        full;
    logic                        issue_ok;

    assign wb_zero_r0  = (R0_ZERO != 0) && (wb_rg == R0_ADDR);
    assign iss_zero_r0 = (R0_ZERO != 0) && (iss_rg == R0_ADDR);
    assign wb_live     = wb_we && !wb_zero_r0;

    // A write-back landing this cycle already retires one pending count.
    assign haz_a = rda_use && cnt_nz[rda_rg] && !(dec[rda_rg] && (cnt[rda_rg] == CNT_ONE));
    assign haz_b = rdb_use && cnt_nz[rdb_rg] && !(dec[rdb_rg] && (cnt[rdb_rg] == CNT_ONE));
    assign full  = iss_we && (cnt[iss_rg] == CNT_MAX) && !(wb_we && (wb_rg == iss_rg));

    assign stall    = iss_valid && (haz_a || haz_b || full);
    assign issue_ok = iss_valid && !stall;

    for (genvar r = 0; r < NREG; r++) begin : g_counter
        assign dec[r] = wb_live && (wb_rg == ADDR_W'(r)) && cnt_nz[r];
        assign inc[r] = issue_ok && iss_we && !iss_zero_r0 && (iss_rg == ADDR_W'(r));

        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc     (inc[r]),
            .dec     (dec[r]),
            .cnt     (cnt[r]),
            .nonzero (cnt_nz[r])
        );
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_live) begin
            regs_d[wb_rg] = wb_data;
        end
    end

    assign wb_err_d = wb_err_q || (wb_live && !cnt_nz[wb_rg]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            wb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            wb_err_q <= wb_err_d;
        end
    end

    always_comb begin
        rda_data = regs_q[rda_rg];
        if ((R0_ZERO != 0) && (rda_rg == R0_ADDR)) begin
            rda_data = '0;
        end else if (wb_we && (wb_rg == rda_rg)) begin
            rda_data = wb_data;
        end
    end

    always_comb begin
        rdb_data = regs_q[rdb_rg];
        if ((R0_ZERO != 0) && (rdb_rg == R0_ADDR)) begin
            rdb_data = '0;
        end else if (wb_we && (wb_rg == rdb_rg)) begin
            rdb_data = wb_data;
        end
    end

    assign wb_err   = wb_err_q;
    assign pend_any = |cnt_nz;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile_scoreboard.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_wb_regfile_scoreboard: directed and randomized checks vs. a model    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_wb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [3:0]  wb_rg;
    logic [31:0] wb_data;
    logic [3:0]  rda_rg;
    logic        rda_use;
    logic [31:0] rda_data;
    logic [3:0]  rdb_rg;
    logic        rdb_use;
    logic [31:0] rdb_data;
    logic        iss_valid;
    logic        iss_we;
    logic [3:0]  iss_rg;
    logic        stall;
    logic        wb_err;
    logic        pend_any;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state: register contents, outstanding writes, error flag.
    logic [31:0] mem_m [16];
    int          cnt_m [16];
    logic        err_m;

    wb_regfile_scoreboard dut (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_rg     (wb_rg),
        .wb_data   (wb_data),
        .rda_rg    (rda_rg),
        .rda_use   (rda_use),
        .rda_data  (rda_data),
        .rdb_rg    (rdb_rg),
        .rdb_use   (rdb_use),
        .rdb_data  (rdb_data),
        .iss_valid (iss_valid),
        .iss_we    (iss_we),
        .iss_rg    (iss_rg),
        .stall     (stall),
        .wb_err    (wb_err),
        .pend_any  (pend_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int eff_m(input logic [3:0] r);
        int e;
        if (r == 4'd0) return 0;
        e = cnt_m[r];
        if (wb_we && wb_rg == r && e > 0) e = e - 1;
        return e;
    endfunction

    function automatic logic stall_m();
        logic hz;
        hz = (rda_use && eff_m(rda_rg) > 0) || (rdb_use && eff_m(rdb_rg) > 0) ||
             (iss_we && cnt_m[iss_rg] == 3 && !(wb_we && wb_rg == iss_rg));
        return iss_valid && hz;
    endfunction

    function automatic logic [31:0] rd_m(input logic [3:0] r);
        if (r == 4'd0) return 32'd0;
        if (wb_we && wb_rg == r) return wb_data;
        return mem_m[r];
    endfunction

    function automatic logic pend_m();
        for (int i = 0; i < 16; i++) if (cnt_m[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            mem_m[i] = 32'd0;
            cnt_m[i] = 0;
        end
        err_m = 1'b0;
    endtask

    task automatic clear_inputs();
        wb_we = 0; wb_rg = 0; wb_data = 0;
        rda_rg = 0; rda_use = 0; rdb_rg = 0; rdb_use = 0;
        iss_valid = 0; iss_we = 0; iss_rg = 0;
    endtask

    // Advance one clock and apply the architectural effect of the held inputs.
    task automatic tick();
        logic s;
        s = stall_m();
        @(posedge clk);
        if (wb_we && wb_rg != 4'd0) begin
            mem_m[wb_rg] = wb_data;
            if (cnt_m[wb_rg] > 0) cnt_m[wb_rg] = cnt_m[wb_rg] - 1;
            else err_m = 1'b1;
        end
        if (iss_valid && !s && iss_we && iss_rg != 4'd0) cnt_m[iss_rg] = cnt_m[iss_rg] + 1;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        model_clear();
        rda_rg = 4'd5; rdb_rg = 4'd9;
        #3;
        tests_run++;
        if ({stall, pend_any, wb_err} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b required 000", {stall, pend_any, wb_err});
        end
        tests_run++;
        if (rda_data !== 32'd0 || rdb_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_read: got %h/%h required 0/0", rda_data, rdb_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_bypass();
        wb_we = 1; wb_rg = 4'd5; wb_data = 32'hDEADBEEF; rda_rg = 4'd5;
        #1;
        tests_run++;
        if (rda_data !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL bypass_read: got %h required deadbeef", rda_data);
        end
        tick();
        wb_we = 0; wb_data = 32'h0;
        #1;
        tests_run++;
        if (rda_data !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL array_read: got %h required deadbeef", rda_data);
        end
        tests_run++;
        if (wb_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL wb_err_unowed: got %b required 1", wb_err);
        end
        clear_inputs();
    endtask

    task automatic test_raw_stall();
        iss_valid = 1; iss_we = 1; iss_rg = 4'd3;
        #1;
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL raw_issue: got stall %b required 0", stall);
        end
        tick();
        iss_we = 0; rda_use = 1; rda_rg = 4'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (stall !== 1'b1) begin
                tests_failed++;
                $display("FAIL raw_hold%0d: got stall %b required 1", i, stall);
            end
            tick();
        end
        wb_we = 1; wb_rg = 4'd3; wb_data = 32'h00000042;
        #1;
        tests_run++;
        if (stall !== 1'b0 || rda_data !== 32'h00000042) begin
            tests_failed++;
            $display("FAIL raw_release: got stall %b data %h required 0 00000042", stall, rda_data);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_full();
        do_reset();
        iss_valid = 1; iss_we = 1; iss_rg = 4'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (stall !== 1'b0) begin
                tests_failed++;
                $display("FAIL full_accept%0d: got stall %b required 0", i, stall);
            end
            tick();
        end
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_block: got stall %b required 1", stall);
        end
        tick();
        wb_we = 1; wb_rg = 4'd7; wb_data = $urandom;
        #1;
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_wb_release: got stall %b required 0", stall);
        end
        tick();
        wb_we = 0;
        #1;
        tests_run++;
        if (stall !== 1'b1 || pend_any !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_still3: got stall %b pend %b required 1 1", stall, pend_any);
        end
        clear_inputs();
        wb_we = 1; wb_rg = 4'd7;
        for (int i = 0; i < 3; i++) begin
            wb_data = $urandom;
            tick();
        end
        clear_inputs();
        #1;
        tests_run++;
        if (pend_any !== 1'b0 || wb_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_drain: got pend %b err %b required 0 0", pend_any, wb_err);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        iss_valid = 1; iss_we = 1; iss_rg = 4'd2;
        tick();
        wb_we = 1; wb_rg = 4'd2; wb_data = 32'h0000_2222;
        #1;
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL same_issue: got stall %b required 0", stall);
        end
        tick();
        clear_inputs();
        iss_valid = 1; rda_use = 1; rda_rg = 4'd2;
        #1;
        tests_run++;
        if (pend_any !== 1'b1 || wb_err !== 1'b0 || stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL same_cnt1: got pend %b err %b stall %b required 1 0 1", pend_any, wb_err, stall);
        end
        clear_inputs();
        wb_we = 1; wb_rg = 4'd2; wb_data = 32'h0;
        tick();
        clear_inputs();
        #1;
        tests_run++;
        if (pend_any !== 1'b0) begin
            tests_failed++;
            $display("FAIL same_drain: got pend %b required 0", pend_any);
        end
    endtask

    task automatic test_r0();
        do_reset();
        wb_we = 1; wb_rg = 4'd0; wb_data = 32'h12345678;
        iss_valid = 1; iss_we = 1; iss_rg = 4'd0;
        rda_use = 1; rda_rg = 4'd0;
        #1;
        tests_run++;
        if (rda_data !== 32'd0 || stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL r0_read: got data %h stall %b required 0 0", rda_data, stall);
        end
        tick();
        wb_we = 0;
        #1;
        tests_run++;
        if (pend_any !== 1'b0 || wb_err !== 1'b0 || stall !== 1'b0 || rda_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL r0_after: got pend %b err %b stall %b data %h required 0 0 0 0",
                     pend_any, wb_err, stall, rda_data);
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        wb_we = 1; wb_rg = 4'd9; wb_data = 32'hCAFE0009;
        iss_valid = 1; iss_we = 1; iss_rg = 4'd4;
        tick();
        wb_we = 0;
        tick();
        iss_we = 0; rda_use = 1; rda_rg = 4'd4; rdb_rg = 4'd9;
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        tests_run++;
        if (stall !== 1'b0 || pend_any !== 1'b0 || rdb_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL async_clear: got stall %b pend %b data %h required 0 0 0",
                     stall, pend_any, rdb_data);
        end
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        wb_we = 1; wb_rg = 4'd4; wb_data = 32'h44;
        tick();
        clear_inputs();
        #1;
        tests_run++;
        if (wb_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_late_wb: got err %b required 1", wb_err);
        end
    endtask

    task automatic test_random();
        int pend_q[$];
        do_reset();
        for (int n = 0; n < 400; n++) begin
            pend_q.delete();
            for (int i = 1; i < 16; i++) if (cnt_m[i] > 0) pend_q.push_back(i);
            wb_we   = ($urandom_range(0, 2) != 0);
            if (pend_q.size() > 0 && $urandom_range(0, 15) != 0)
                wb_rg = 4'(pend_q[$urandom_range(0, pend_q.size() - 1)]);
            else
                wb_rg = 4'($urandom_range(0, 15));
            wb_data   = $urandom;
            iss_valid = $urandom_range(0, 1);
            iss_we    = $urandom_range(0, 1);
            iss_rg    = 4'($urandom_range(0, 7));
            rda_rg    = 4'($urandom_range(0, 7));
            rdb_rg    = 4'($urandom_range(0, 7));
            rda_use   = $urandom_range(0, 1);
            rdb_use   = $urandom_range(0, 1);
            #1;
            tests_run++;
            if (rda_data !== rd_m(rda_rg) || rdb_data !== rd_m(rdb_rg) || stall !== stall_m() ||
                pend_any !== pend_m() || wb_err !== err_m) begin
                tests_failed++;
                $display("FAIL random_cycle%0d: got a=%h b=%h st=%b pa=%b er=%b required a=%h b=%h st=%b pa=%b er=%b",
                         n, rda_data, rdb_data, stall, pend_any, wb_err,
                         rd_m(rda_rg), rd_m(rdb_rg), stall_m(), pend_m(), err_m);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_raw_stall();
        test_full();
        test_same_cycle();
        test_r0();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
